// File: rtl/mimo_frame_sequencer.sv
// mimo_frame_sequencer
//   Feeds the 4x4 MIMO sphere detector from a beat stream: four channel-row
//   beats, then one or more received-vector beats per frame. Beats are issued
//   one at a time from a single holding register. At most one received vector
//   is in flight at a time. Each detector result, or a timeout entry,
//   lands in a small output FIFO tagged with last/error flags.
//
// Ports
//   Clk, Reset                  clock, async active-high reset
//   s_valid/s_ready/s_is_channel/s_last/s_data   upstream beat stream
//   det_in_valid/det_in_ready/det_flag/det_data  beat issue to detector
//   det_out_ready/det_out_data  detector result pulse + 12-bit symbols
//   m_valid/m_ready/m_data/m_last/m_err          output FIFO head
//   frame_err, timeout_err      single-cycle error pulses
//   frame_cnt                   completed frames (wraps)
//   busy                        frame in progress or FIFO not empty
module mimo_frame_sequencer #(
    parameter int I_WIDTH     = 16,
    parameter int OFIFO_DEPTH = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int FCNT_W      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_is_channel,
    input  logic                 s_last,
    input  logic [I_WIDTH*8-1:0] s_data,
    output logic                 det_in_valid,
    output logic                 det_flag,
    output logic [I_WIDTH*8-1:0] det_data,
    input  logic                 det_in_ready,
    input  logic                 det_out_ready,
    input  logic [11:0]          det_out_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [11:0]          m_data,
    output logic                 m_last,
    output logic                 m_err,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic                 busy
);
    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam int TW = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {LOAD_H, SEND_Y, WAIT_DET} state_t;

    state_t        state;
    logic          hold;
    logic          cur_last;
    logic [1:0]    row_cnt;
    logic [TW-1:0] timer;

    logic [13:0]   mem [OFIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_count;

    logic          s_acc, d_acc, push, pop;
    logic [13:0]   push_word;

    assign det_in_valid = hold;
    assign s_acc        = s_valid && s_ready;
    assign d_acc        = hold && det_in_ready;
    assign pop          = (fifo_count != '0) && m_ready;

    // In SEND_Y a vector is only taken when a FIFO slot is free, so the
    // eventual result (or timeout entry) always has room.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            LOAD_H:  s_ready = !hold;
            SEND_Y:  s_ready = !hold && (fifo_count < (AW+1)'(OFIFO_DEPTH));
            default: s_ready = 1'b0;
        endcase
    end

    // A real result wins over a timeout landing in the same cycle.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state == WAIT_DET) begin
            if (det_out_ready) begin
                push      = 1'b1;
                push_word = {cur_last, 1'b0, det_out_data};
            end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                push      = 1'b1;
                push_word = {cur_last, 1'b1, 12'h000};
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= LOAD_H;
            hold        <= 1'b0;
            det_flag    <= 1'b0;
            det_data    <= '0;
            cur_last    <= 1'b0;
            row_cnt     <= '0;
            timer       <= '0;
            frame_cnt   <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (d_acc) hold <= 1'b0;
            case (state)
                LOAD_H: begin
                    if (s_acc) begin
                        if (s_is_channel) begin
                            hold     <= 1'b1;
                            det_flag <= 1'b1;
                            det_data <= s_data;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    if (d_acc) begin
                        if (row_cnt == 2'd3) begin
                            row_cnt <= '0;
                            state   <= SEND_Y;
                        end else begin
                            row_cnt <= row_cnt + 2'd1;
                        end
                    end
                end
                SEND_Y: begin
                    if (s_acc) begin
                        if (!s_is_channel) begin
                            hold     <= 1'b1;
                            det_flag <= 1'b0;
                            det_data <= s_data;
                            cur_last <= s_last;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    if (d_acc) begin
                        state <= WAIT_DET;
                        timer <= '0;
                    end
                end
                default: begin
                    timer <= timer + TW'(1);
                    if (push) begin
                        if (!det_out_ready) timeout_err <= 1'b1;
                        if (cur_last) begin
                            state     <= LOAD_H;
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                        end else begin
                            state <= SEND_Y;
                        end
                    end
                end
            endcase
        end
    end

    // Output FIFO; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_valid = (fifo_count != '0);
    assign {m_last, m_err, m_data} = m_valid ? mem[rd_ptr] : 14'h0;
    assign busy = (state != LOAD_H) || (row_cnt != '0) || hold || (fifo_count != '0);

endmodule

// File: tb/tb_mimo_frame_sequencer.sv
module tb_mimo_frame_sequencer;
    localparam int IW = 16, D = 4, TO = 64, FW = 16, DW = IW*8;

    logic          Clk = 0, Reset = 1;
    logic          s_valid = 0, s_is_channel = 0, s_last = 0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, det_in_valid, det_flag;
    logic [DW-1:0] det_data;
    logic          det_in_ready = 1, det_out_ready = 0;
    logic [11:0]   det_out_data = '0;
    logic          m_valid, m_ready = 1, m_last, m_err;
    logic [11:0]   m_data;
    logic          frame_err, timeout_err, busy;
    logic [FW-1:0] frame_cnt;

    mimo_frame_sequencer #(.I_WIDTH(IW), .OFIFO_DEPTH(D), .TIMEOUT_CYC(TO), .FCNT_W(FW)) dut (
        .Clk(Clk), .Reset(Reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_is_channel(s_is_channel), .s_last(s_last), .s_data(s_data),
        .det_in_valid(det_in_valid), .det_flag(det_flag), .det_data(det_data),
        .det_in_ready(det_in_ready), .det_out_ready(det_out_ready), .det_out_data(det_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_err(m_err),
        .frame_err(frame_err), .timeout_err(timeout_err), .frame_cnt(frame_cnt), .busy(busy));

    always #5 Clk = ~Clk;

    int nchk = 0, nfail = 0;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---- behavioural model: phase 0 = loading rows, 1 = sending vectors, 2 = awaiting result
    int            ph = 0, rows = 0, tmr = 0, fcnt = 0;
    bit            mh = 0, mflag = 0, mlast = 0, eferr = 0, eterr = 0;
    logic [DW-1:0] mdata = '0;
    logic [13:0]   fq[$];

    function automatic bit mod_sready();
        if (ph == 0) return !mh;
        if (ph == 1) return !mh && (fq.size() < D);
        return 1'b0;
    endfunction

    initial forever begin : model
        bit sr, dacc, pushed;
        @(posedge Clk or posedge Reset);
        if (Reset) begin
            ph = 0; rows = 0; tmr = 0; fcnt = 0; mh = 0; mflag = 0; mlast = 0;
            eferr = 0; eterr = 0; mdata = '0; fq.delete();
        end else begin
            sr = mod_sready(); dacc = mh && det_in_ready; pushed = 0;
            eferr = 0; eterr = 0;
            if (fq.size() != 0 && m_ready) void'(fq.pop_front());
            if (dacc) mh = 0;
            case (ph)
                0: begin
                    if (s_valid && sr) begin
                        if (s_is_channel) begin mh = 1; mflag = 1; mdata = s_data; end
                        else eferr = 1;
                    end
                    if (dacc) begin rows++; if (rows == 4) begin rows = 0; ph = 1; end end
                end
                1: begin
                    if (s_valid && sr) begin
                        if (!s_is_channel) begin mh = 1; mflag = 0; mdata = s_data; mlast = s_last; end
                        else eferr = 1;
                    end
                    if (dacc) begin ph = 2; tmr = 0; end
                end
                default: begin
                    if (det_out_ready) begin fq.push_back({mlast, 1'b0, det_out_data}); pushed = 1; end
                    else if (tmr == TO-1) begin fq.push_back({mlast, 1'b1, 12'h000}); pushed = 1; eterr = 1; end
                    tmr++;
                    if (pushed) begin
                        if (mlast) begin ph = 0; fcnt = (fcnt + 1) % (1 << FW); end
                        else ph = 1;
                    end
                end
            endcase
        end
    end

    // ---- compare process + observation logs
    logic [13:0] olog[$];
    bit          flog[$];
    int          ferr_n = 0, terr_n = 0;

    initial forever begin : cmp
        logic [13:0] hd;
        @(negedge Clk);
        if (Reset) begin
            chk("rst_s_ready", DW'(s_ready), 1);
            chk("rst_det_in_valid", DW'(det_in_valid), 0);
            chk("rst_m_valid", DW'(m_valid), 0);
            chk("rst_m_data", DW'({m_last, m_err, m_data}), 0);
            chk("rst_frame_cnt", DW'(frame_cnt), 0);
            chk("rst_busy", DW'(busy), 0);
            chk("rst_pulses", DW'({frame_err, timeout_err}), 0);
        end else begin
            hd = (fq.size() != 0) ? fq[0] : 14'h0;
            chk("s_ready", DW'(s_ready), DW'(mod_sready()));
            chk("det_in_valid", DW'(det_in_valid), DW'(mh));
            if (mh) begin
                chk("det_flag", DW'(det_flag), DW'(mflag));
                chk("det_data", det_data, mdata);
            end
            chk("m_valid", DW'(m_valid), DW'(fq.size() != 0));
            chk("m_head", DW'({m_last, m_err, m_data}), DW'(hd));
            chk("busy", DW'(busy), DW'(ph != 0 || rows != 0 || mh || fq.size() != 0));
            chk("frame_cnt", DW'(frame_cnt), DW'(fcnt));
            chk("frame_err", DW'(frame_err), DW'(eferr));
            chk("timeout_err", DW'(timeout_err), DW'(eterr));
            if (m_valid && m_ready) olog.push_back({m_last, m_err, m_data});
            if (det_in_valid && det_in_ready) flog.push_back(det_flag);
            if (frame_err) ferr_n++;
            if (timeout_err) terr_n++;
        end
    end

    // ---- detector stand-in: answers each accepted vector after 'lat' cycles
    int          cd = -1, lat = 20;
    bit          resp_en = 1, late_pulse = 0;
    logic [11:0] rq[$];

    initial forever begin : detm
        @(negedge Clk);
        det_out_ready = 0;
        if (Reset) cd = -1;
        else begin
            if (late_pulse) begin
                det_out_ready = 1; det_out_data = 12'h5A5; late_pulse = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    det_out_ready = 1;
                    det_out_data = (rq.size() != 0) ? rq.pop_front() : 12'h000;
                    cd = -1;
                end
            end
            if (det_in_valid && det_in_ready && !det_flag && resp_en) cd = lat;
        end
    end

    // ---- stimulus helpers
    task automatic cyc(int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic send(bit ch, bit last, logic [DW-1:0] d);
        int n = 0;
        @(posedge Clk); #1;
        s_valid = 1; s_is_channel = ch; s_last = last; s_data = d;
        forever begin
            @(negedge Clk);
            if (s_ready) break;
            n++;
            if (n > 3000) begin
                nchk++; nfail++;
                $display("FAIL send_timeout actual=no_accept expected=accept t=%0t", $time);
                break;
            end
        end
        @(posedge Clk); #1;
        s_valid = 0;
    endtask

    task automatic send_rows();
        for (int i = 0; i < 4; i++) send(1, 0, {8{16'h1000 + 16'(i)}});
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge Clk); n++; end while (busy && n < 3000);
        chk("wait_idle", DW'(busy), 0);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1 Reset = 1;
        @(posedge Clk); #1 Reset = 0;
    endtask

    initial begin
        logic [6:0] fl;
        cyc(3); #1 Reset = 0;

        // T1: basic frame, 3 vectors
        rq = '{12'hABC, 12'h123, 12'hFFF}; olog.delete(); flog.delete();
        send_rows();
        send(0, 0, {8{16'hA001}});
        send(0, 0, {8{16'hA002}});
        send(0, 1, {8{16'hA003}});
        wait_idle();
        fl = '0;
        foreach (flog[i]) if (i < 7) fl[6-i] = flog[i];
        chk("t1_flag_seq", DW'({flog.size() == 7, fl}), DW'({1'b1, 7'b1111000}));
        chk("t1_nres", DW'(olog.size()), 3);
        if (olog.size() == 3) begin
            chk("t1_r0", DW'(olog[0]), DW'({2'b00, 12'hABC}));
            chk("t1_r1", DW'(olog[1]), DW'({2'b00, 12'h123}));
            chk("t1_r2", DW'(olog[2]), DW'({2'b10, 12'hFFF}));
        end
        chk("t1_frame_cnt", DW'(frame_cnt), 1);

        // T2: downstream stalled; FIFO fills and blocks the 5th vector
        m_ready = 0; olog.delete();
        rq = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055, 12'h066};
        fork
            begin
                send_rows();
                for (int i = 0; i < 6; i++) send(0, i == 5, {8{16'hB000 + 16'(i)}});
            end
            begin
                cyc(400);
                @(negedge Clk);
                chk("t2_full_s_ready", DW'(s_ready), 0);
                chk("t2_full_m_valid", DW'(m_valid), 1);
                chk("t2_full_det_in_valid", DW'(det_in_valid), 0);
                @(posedge Clk); #1 m_ready = 1;
            end
        join
        wait_idle();
        chk("t2_nres", DW'(olog.size()), 6);
        if (olog.size() == 6) begin
            chk("t2_r0", DW'(olog[0]), DW'({2'b00, 12'h011}));
            chk("t2_r3", DW'(olog[3]), DW'({2'b00, 12'h044}));
            chk("t2_r5", DW'(olog[5]), DW'({2'b10, 12'h066}));
        end
        chk("t2_frame_cnt", DW'(frame_cnt), 2);

        // T3: vector as first beat after reset is dropped
        do_reset();
        ferr_n = 0; flog.delete();
        send(0, 0, {8{16'hDEAD}});
        cyc(3); @(negedge Clk);
        chk("t3_ferr_pulses", DW'(ferr_n), 1);
        chk("t3_busy", DW'(busy), 0);
        chk("t3_not_forwarded", DW'(flog.size()), 0);
        send_rows();
        cyc(3); @(negedge Clk);
        chk("t3_rows_loaded", DW'(flog.size()), 4);

        // T4: detector silent -> timeout entry, late pulse ignored
        resp_en = 0; olog.delete(); terr_n = 0;
        send(0, 0, {8{16'hC001}});
        cyc(TO + 6); @(negedge Clk);
        chk("t4_terr_pulses", DW'(terr_n), 1);
        chk("t4_nres", DW'(olog.size()), 1);
        if (olog.size() == 1) chk("t4_timeout_entry", DW'(olog[0]), DW'({2'b01, 12'h000}));
        late_pulse = 1;
        cyc(4); @(negedge Clk);
        chk("t4_late_ignored", DW'(olog.size()), 1);
        resp_en = 1; rq = '{12'h777};
        send(0, 1, {8{16'hC002}});
        wait_idle();
        chk("t4_frame_cnt", DW'(frame_cnt), 1);

        // T5: detector not ready for 10 cycles
        @(posedge Clk); #1 det_in_ready = 0;
        send(1, 0, {8{16'hE000}});
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("t5_valid", DW'(det_in_valid), 1);
            chk("t5_data", det_data, {8{16'hE000}});
            chk("t5_s_ready", DW'(s_ready), 0);
        end
        @(posedge Clk); #1 det_in_ready = 1;
        for (int i = 1; i < 4; i++) send(1, 0, {8{16'hE000 + 16'(i)}});
        rq = '{12'h0AA};
        send(0, 1, {8{16'hE100}});
        wait_idle();

        // T6: reset while waiting with two results queued
        m_ready = 0; lat = 20; rq = '{12'h101, 12'h202};
        send_rows();
        send(0, 0, {8{16'hF001}});
        send(0, 0, {8{16'hF002}});
        cyc(3); lat = 200;
        send(0, 0, {8{16'hF003}});
        cyc(30); @(negedge Clk);
        chk("t6_pre_m_valid", DW'(m_valid), 1);
        do_reset();
        @(negedge Clk);
        chk("t6_m_valid", DW'(m_valid), 0);
        chk("t6_frame_cnt", DW'(frame_cnt), 0);
        chk("t6_s_ready", DW'(s_ready), 1);
        m_ready = 1; lat = 20; rq.delete();
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
